// File: rtl/processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : processor_core
//  Description : Multicycle 32-bit core (FETCH / EXEC / MEM). Instruction and
//                data memories are external synchronous RAM/ROM; the register
//                file is external with combinational reads and a write port
//                committed at the rising edge.
//  Ports       : clock, reset             - sole clock, sync active-high reset
//                address_imem / q_imem    - instruction address (PC) / word
//                ctrl_writeEnable, ctrl_writeReg, data_writeReg - RF write
//                ctrl_readRegA/B, data_readRegA/B               - RF reads
//                wren, address_dmem, data / q_dmem              - data RAM
//  Revision    : 1.0 - initial release
// ============================================================================
module processor_core (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2
    } state_t;

    localparam logic [4:0] c_OP_RTYPE = 5'b00000;
    localparam logic [4:0] c_OP_J     = 5'b00001;
    localparam logic [4:0] c_OP_BNE   = 5'b00010;
    localparam logic [4:0] c_OP_JAL   = 5'b00011;
    localparam logic [4:0] c_OP_JR    = 5'b00100;
    localparam logic [4:0] c_OP_ADDI  = 5'b00101;
    localparam logic [4:0] c_OP_BLT   = 5'b00110;
    localparam logic [4:0] c_OP_SW    = 5'b00111;
    localparam logic [4:0] c_OP_LW    = 5'b01000;
    localparam logic [4:0] c_OP_SETX  = 5'b10101;
    localparam logic [4:0] c_OP_BEX   = 5'b10110;

    localparam logic [4:0] c_ALU_ADD = 5'b00000;
    localparam logic [4:0] c_ALU_SUB = 5'b00001;
    localparam logic [4:0] c_ALU_AND = 5'b00010;
    localparam logic [4:0] c_ALU_OR  = 5'b00011;
    localparam logic [4:0] c_ALU_SLL = 5'b00100;
    localparam logic [4:0] c_ALU_SRA = 5'b00101;

    localparam logic [4:0] c_REG_STATUS = 5'd30;
    localparam logic [4:0] c_REG_LINK   = 5'd31;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;

    // The ROM keeps presenting the same word while the PC is held, so the
    // instruction is decoded straight from q_imem in both EXEC and MEM.
    logic [4:0]  w_opcode, w_rd, w_rs, w_rt, w_shamt, w_aluop;
    logic [31:0] w_imm_n, w_imm_t, w_pc_inc;
    logic [31:0] w_sum_ab, w_diff_ab, w_sum_an;
    logic        w_ovf_add, w_ovf_sub, w_ovf_addi;
    logic        w_we, w_wren;

    assign w_opcode = q_imem[31:27];
    assign w_rd     = q_imem[26:22];
    assign w_rs     = q_imem[21:17];
    assign w_rt     = q_imem[16:12];
    assign w_shamt  = q_imem[11:7];
    assign w_aluop  = q_imem[6:2];
    assign w_imm_n  = {{15{q_imem[16]}}, q_imem[16:0]};
    assign w_imm_t  = {5'd0, q_imem[26:0]};
    assign w_pc_inc = r_pc + 32'd1;

    assign w_sum_ab  = data_readRegA + data_readRegB;
    assign w_diff_ab = data_readRegA - data_readRegB;
    assign w_sum_an  = data_readRegA + w_imm_n;   // addi result and rs+N address

    // Signed overflow: operands (effective, for sub) share a sign the result lacks.
    assign w_ovf_add  = (data_readRegA[31] == data_readRegB[31]) && (w_sum_ab[31]  != data_readRegA[31]);
    assign w_ovf_sub  = (data_readRegA[31] != data_readRegB[31]) && (w_diff_ab[31] != data_readRegA[31]);
    assign w_ovf_addi = (data_readRegA[31] == w_imm_n[31])       && (w_sum_an[31]  != data_readRegA[31]);

    assign address_imem = r_pc;

    // Register-file read port selection
    always_comb begin
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        case (w_opcode)
            c_OP_RTYPE:          begin ctrl_readRegA = w_rs; ctrl_readRegB = w_rt; end
            c_OP_ADDI, c_OP_LW:  ctrl_readRegA = w_rs;
            c_OP_SW:             begin ctrl_readRegA = w_rs; ctrl_readRegB = w_rd; end
            c_OP_BNE, c_OP_BLT:  begin ctrl_readRegA = w_rd; ctrl_readRegB = w_rs; end
            c_OP_JR:             ctrl_readRegA = w_rd;
            c_OP_BEX:            ctrl_readRegA = c_REG_STATUS;
            default:             ;
        endcase
    end

    // Next-state, next-PC and datapath outputs
    always_comb begin
        w_next_state  = S_FETCH;
        w_next_pc     = r_pc;
        w_we          = 1'b0;
        ctrl_writeReg = 5'd0;
        data_writeReg = 32'd0;
        w_wren        = 1'b0;
        address_dmem  = 32'd0;
        data          = 32'd0;
        case (r_state)
            S_FETCH: w_next_state = S_EXEC;
            S_EXEC: begin
                w_next_pc = w_pc_inc;
                case (w_opcode)
                    c_OP_RTYPE: begin
                        w_we          = 1'b1;
                        ctrl_writeReg = w_rd;
                        case (w_aluop)
                            c_ALU_ADD: begin
                                if (w_ovf_add) begin
                                    ctrl_writeReg = c_REG_STATUS;
                                    data_writeReg = 32'd1;
                                end else begin
                                    data_writeReg = w_sum_ab;
                                end
                            end
                            c_ALU_SUB: begin
                                if (w_ovf_sub) begin
                                    ctrl_writeReg = c_REG_STATUS;
                                    data_writeReg = 32'd3;
                                end else begin
                                    data_writeReg = w_diff_ab;
                                end
                            end
                            c_ALU_AND: data_writeReg = data_readRegA & data_readRegB;
                            c_ALU_OR:  data_writeReg = data_readRegA | data_readRegB;
                            c_ALU_SLL: data_writeReg = data_readRegA << w_shamt;
                            c_ALU_SRA: data_writeReg = $signed(data_readRegA) >>> w_shamt;
                            default:   w_we = 1'b0;
                        endcase
                    end
                    c_OP_ADDI: begin
                        w_we = 1'b1;
                        if (w_ovf_addi) begin
                            ctrl_writeReg = c_REG_STATUS;
                            data_writeReg = 32'd2;
                        end else begin
                            ctrl_writeReg = w_rd;
                            data_writeReg = w_sum_an;
                        end
                    end
                    c_OP_SW: begin
                        w_wren       = 1'b1;
                        address_dmem = w_sum_an;
                        data         = data_readRegB;
                    end
                    c_OP_LW: begin
                        // PC holds until the MEM cycle completes the load
                        w_next_state = S_MEM;
                        w_next_pc    = r_pc;
                        address_dmem = w_sum_an;
                    end
                    c_OP_BNE: if (data_readRegA != data_readRegB) w_next_pc = w_pc_inc + w_imm_n;
                    c_OP_BLT: if ($signed(data_readRegA) < $signed(data_readRegB)) w_next_pc = w_pc_inc + w_imm_n;
                    c_OP_J:   w_next_pc = w_imm_t;
                    c_OP_JAL: begin
                        w_we          = 1'b1;
                        ctrl_writeReg = c_REG_LINK;
                        data_writeReg = w_pc_inc;
                        w_next_pc     = w_imm_t;
                    end
                    c_OP_JR:  w_next_pc = data_readRegA;
                    c_OP_SETX: begin
                        w_we          = 1'b1;
                        ctrl_writeReg = c_REG_STATUS;
                        data_writeReg = w_imm_t;
                    end
                    c_OP_BEX: if (data_readRegA != 32'd0) w_next_pc = w_imm_t;
                    default: ;
                endcase
            end
            S_MEM: begin
                w_next_pc     = w_pc_inc;
                address_dmem  = w_sum_an;
                w_we          = 1'b1;
                ctrl_writeReg = w_rd;
                data_writeReg = q_dmem;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Writes are killed while reset is high so an abandoned instruction
    // commits nothing; r0 is never a write target.
    assign ctrl_writeEnable = w_we && (ctrl_writeReg != 5'd0) && !reset;
    assign wren             = w_wren && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_processor_core
//  Description : Bench for processor_core with ROM, RAM and register-file
//                models. Expected write events (register or memory, with the
//                cycle they must appear in) are queued up front; a monitor
//                compares every write the core presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_imem, q_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB;
    logic        wren;
    logic [31:0] address_dmem, data, q_dmem;

    processor_core dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wren             (wren),
        .address_dmem     (address_dmem),
        .data             (data),
        .q_dmem           (q_dmem)
    );

    always #5 clock = ~clock;

    logic [31:0] rom [0:63];
    logic [31:0] ram [0:63];
    logic [31:0] rf  [0:31];

    always @(posedge clock) begin
        q_imem <= rom[address_imem[5:0]];
        q_dmem <= ram[address_dmem[5:0]];
        if (wren) ram[address_dmem[5:0]] <= data;
        if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
    end
    assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
    assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

    int cyc;
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        bit          is_mem;
        logic [31:0] addr;
        logic [31:0] dat;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] enc_r(input int aluop, input int rd, input int rs, input int rt, input int shamt);
        logic [4:0] a, d, s, t, sh;
        a = aluop[4:0]; d = rd[4:0]; s = rs[4:0]; t = rt[4:0]; sh = shamt[4:0];
        return {5'b00000, d, s, t, sh, a, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input int rd, input int rs, input int imm);
        logic [4:0]  d, s;
        logic [16:0] n;
        d = rd[4:0]; s = rs[4:0]; n = imm[16:0];
        return {op, d, s, n};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input int t);
        logic [26:0] tt;
        tt = t[26:0];
        return {op, tt};
    endfunction

    task automatic push_exp(input bit m, input int a, input logic [31:0] d, input int c);
        exp_t e;
        e.is_mem = m; e.addr = a; e.dat = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_evt(input bit m, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: mem=%0d addr=%0d data=%h cyc=%0d, required no write", m, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_mem != m || e.addr !== a || e.dat !== d || e.cyc != cyc) begin
                n_err++;
                $display("FAIL write_event: got mem=%0d addr=%0d data=%h cyc=%0d, required mem=%0d addr=%0d data=%h cyc=%0d",
                         m, a, d, cyc, e.is_mem, e.addr, e.dat, e.cyc);
            end
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (reset) begin
            n_cmp++;
            if (ctrl_writeEnable || wren) begin
                n_err++;
                $display("FAIL reset_quiet: we=%0b wren=%0b, required 0/0", ctrl_writeEnable, wren);
            end
        end else begin
            if (ctrl_writeEnable) check_evt(1'b0, {27'd0, ctrl_writeReg}, data_writeReg);
            if (wren)             check_evt(1'b1, address_dmem, data);
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (10) @(posedge clock);
    endtask

    localparam logic [4:0] OP_J = 5'b00001, OP_BNE = 5'b00010, OP_JAL = 5'b00011, OP_JR = 5'b00100,
                           OP_ADDI = 5'b00101, OP_BLT = 5'b00110, OP_SW = 5'b00111, OP_LW = 5'b01000,
                           OP_SETX = 5'b10101, OP_BEX = 5'b10110;

    initial begin
        for (int i = 0; i < 64; i++) begin rom[i] = 32'd0; ram[i] = 32'd0; end
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;

        // ---------------- phase 1 program ----------------
        rom[0]  = enc_i(OP_ADDI, 1, 0, 5);
        rom[1]  = enc_i(OP_ADDI, 2, 0, 7);
        rom[2]  = enc_r(0, 3, 1, 2, 0);          // add r3,r1,r2
        rom[3]  = enc_i(OP_ADDI, 1, 0, 9);
        rom[4]  = enc_i(OP_SW, 1, 0, 4);
        rom[5]  = enc_i(OP_LW, 4, 0, 4);
        rom[6]  = enc_i(OP_ADDI, 6, 0, 1);
        rom[7]  = enc_r(4, 6, 6, 0, 31);         // sll r6,r6,31
        rom[8]  = enc_i(OP_ADDI, 7, 0, -1);
        rom[9]  = enc_r(1, 1, 7, 6, 0);          // sub r1,r7,r6
        rom[10] = enc_r(0, 5, 1, 1, 0);          // add overflow
        rom[11] = enc_r(1, 5, 6, 1, 0);          // sub overflow
        rom[12] = enc_i(OP_ADDI, 9, 6, -1);      // addi overflow
        rom[13] = enc_r(5, 10, 6, 0, 4);         // sra
        rom[14] = enc_r(2, 11, 7, 2, 0);         // and
        rom[15] = enc_r(3, 12, 2, 6, 0);         // or
        rom[16] = enc_i(OP_ADDI, 0, 0, 3);       // write to r0 suppressed
        rom[17] = enc_i(OP_BNE, 1, 2, 2);        // taken -> 20
        rom[18] = enc_i(OP_ADDI, 13, 0, 1);
        rom[19] = enc_i(OP_ADDI, 13, 0, 2);
        rom[20] = enc_i(OP_BLT, 7, 0, 1);        // -1 < 0 taken -> 22
        rom[21] = enc_i(OP_ADDI, 13, 0, 3);
        rom[22] = enc_i(OP_BNE, 2, 2, 5);        // not taken
        rom[23] = enc_j(OP_JAL, 30);
        rom[24] = enc_i(OP_ADDI, 14, 0, 44);
        rom[25] = enc_j(OP_SETX, 4);
        rom[26] = enc_j(OP_BEX, 40);
        rom[27] = enc_i(OP_ADDI, 13, 0, 4);
        rom[30] = enc_i(OP_ADDI, 15, 0, 30);
        rom[31] = enc_i(OP_JR, 31, 0, 0);
        rom[40] = enc_j(OP_SETX, 0);
        rom[41] = enc_j(OP_BEX, 50);             // r30=0 -> falls through
        rom[42] = enc_i(OP_ADDI, 16, 0, 7);
        rom[43] = enc_i(OP_BLT, 2, 0, 9);        // 7 < 0 not taken
        rom[44] = enc_r(6, 17, 1, 1, 0);         // undefined aluop
        rom[45] = {5'b11111, 5'd17, 22'd5};      // undefined opcode
        rom[46] = enc_j(OP_J, 46);

        push_exp(0, 1,  32'd5,        1);
        push_exp(0, 2,  32'd7,        3);
        push_exp(0, 3,  32'd12,       5);
        push_exp(0, 1,  32'd9,        7);
        push_exp(1, 4,  32'd9,        9);
        push_exp(0, 4,  32'd9,        12);
        push_exp(0, 6,  32'd1,        14);
        push_exp(0, 6,  32'h80000000, 16);
        push_exp(0, 7,  32'hFFFFFFFF, 18);
        push_exp(0, 1,  32'h7FFFFFFF, 20);
        push_exp(0, 30, 32'd1,        22);
        push_exp(0, 30, 32'd3,        24);
        push_exp(0, 30, 32'd2,        26);
        push_exp(0, 10, 32'hF8000000, 28);
        push_exp(0, 11, 32'd7,        30);
        push_exp(0, 12, 32'h80000007, 32);
        push_exp(0, 31, 32'd24,       42);
        push_exp(0, 15, 32'd30,       44);
        push_exp(0, 14, 32'd44,       48);
        push_exp(0, 30, 32'd4,        50);
        push_exp(0, 30, 32'd0,        54);
        push_exp(0, 16, 32'd7,        58);

        repeat (3) @(posedge clock);
        #1;
        check_val("reset_pc", address_imem, 32'd0);
        check_val("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
        check_val("reset_wren", {31'd0, wren}, 32'd0);
        reset = 1'b0;

        drain("phase1");
        check_val("ram4", ram[4], 32'd9);
        check_val("r0", rf[0], 32'd0);
        check_val("r5_unchanged", rf[5], 32'd0);
        check_val("r13_skipped", rf[13], 32'd0);
        check_val("r17_noop", rf[17], 32'd0);
        check_val("r30_final", rf[30], 32'd0);
        check_val("pc_loop", address_imem, 32'd46);

        // ---------------- phase 2: reset during lw MEM ----------------
        reset = 1'b1;
        rom[0] = enc_i(OP_ADDI, 18, 0, 1);
        rom[1] = enc_i(OP_LW, 8, 0, 4);
        rom[2] = enc_j(OP_J, 2);
        push_exp(0, 18, 32'd1, 1);
        push_exp(0, 18, 32'd1, 1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);             // now in the lw MEM cycle
        #1 reset = 1'b1;
        rom[1] = enc_j(OP_J, 1);
        @(posedge clock);
        #1;
        check_val("midlw_pc", address_imem, 32'd0);
        reset = 1'b0;
        drain("phase2");
        check_val("r8_not_loaded", rf[8], 32'd0);
        check_val("r18", rf[18], 32'd1);
        check_val("pc_after_reset", address_imem, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
